regfile_write_arbiter: RTL and testbench



---
 rtl/wb_pkg.sv | 11 +
 rtl/ll_result_fifo.sv | 65 ++++++
 rtl/regfile_write_arbiter.sv | 68 ++++++
 tb/tb_regfile_write_arbiter.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared types and widths for the register-file write arbiter.
package wb_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;
  typedef struct packed {
    logic live;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ll_entry_t;
endpackage

// File: rtl/ll_result_fifo.sv
// ll_result_fifo: circular buffer of long-latency results with squash-by-address and live-address lookup.
module ll_result_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  ll_entry_t         push_entry,
  input  logic              pop,
  input  logic              squash_en,
  input  logic [ADDR_W-1:0] squash_addr,
  input  logic [ADDR_W-1:0] q_addr_1,
  input  logic [ADDR_W-1:0] q_addr_2,
  output ll_entry_t         head,
  output logic [CW-1:0]     count,
  output logic              hit_1,
  output logic              hit_2
);
  ll_entry_t mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i].live <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (squash_en && mem[i].live && mem[i].addr == squash_addr) mem[i].live <= 1'b0;
      if (pop) begin
        mem[rd_ptr].live <= 1'b0;
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr <= wr_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_comb begin
    hit_1 = 1'b0;
    hit_2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_1 = hit_1 | (mem[i].live && mem[i].addr == q_addr_1);
      hit_2 = hit_2 | (mem[i].live && mem[i].addr == q_addr_2);
    end
    hit_1 = hit_1 && q_addr_1 != REG_ZERO;
    hit_2 = hit_2 && q_addr_2 != REG_ZERO;
  end
`ifdef WB_TRACE_EN
  logic [DATA_W-1:0] squash_cnt, kills;
  always_comb begin
    kills = DATA_W'(push && squash_en && push_entry.addr == squash_addr);
    for (int i = 0; i < DEPTH; i++)
      kills = kills + DATA_W'(squash_en && mem[i].live && mem[i].addr == squash_addr);
  end
  always_ff @(posedge clk) squash_cnt <= rst ? '0 : squash_cnt + kills;
`endif
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: merges pipeline writeback and buffered long-latency results onto one register-file write port.
module regfile_write_arbiter
  import wb_pkg::*;
#(
  parameter int LL_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ll_valid,
  output logic              ll_ready,
  input  logic [ADDR_W-1:0] ll_addr,
  input  logic [DATA_W-1:0] ll_data,
  input  logic [ADDR_W-1:0] chk_addr_1,
  input  logic [ADDR_W-1:0] chk_addr_2,
  output logic              chk_pending_1,
  output logic              chk_pending_2,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic              write_enabled,
  output logic              ll_empty
);
  localparam int CW = $clog2(LL_DEPTH) + 1;
  logic [CW-1:0] count;
  logic wb_go, push, pop;
  ll_entry_t head, push_entry;
  assign wb_go = wb_valid && wb_addr != REG_ZERO;
  assign ll_ready = count < CW'(LL_DEPTH);
  assign ll_empty = count == '0;
  assign push = ll_valid && ll_ready;
  assign pop = !wb_go && !ll_empty;
  assign push_entry = '{live: ll_addr != REG_ZERO && !(wb_go && ll_addr == wb_addr),
                        addr: ll_addr, data: ll_data};
  ll_result_fifo #(.DEPTH(LL_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .push_entry(push_entry),
    .pop(pop),
    .squash_en(wb_go),
    .squash_addr(wb_addr),
    .q_addr_1(chk_addr_1),
    .q_addr_2(chk_addr_2),
    .head(head),
    .count(count),
    .hit_1(chk_pending_1),
    .hit_2(chk_pending_2)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      write_addr <= '0;
      write_data <= '0;
      write_enabled <= 1'b0;
    end else if (wb_go) begin
      write_addr <= wb_addr;
      write_data <= wb_data;
      write_enabled <= 1'b1;
    end else if (pop) begin
      write_addr <= head.addr;
      write_data <= head.data;
      write_enabled <= head.live;
    end else begin
      write_enabled <= 1'b0;
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: scoreboard bench with a queue-based reference model of the write arbiter.
module tb_regfile_write_arbiter;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wb_valid = 1'b0, ll_valid = 1'b0;
  logic [4:0] wb_addr = '0, ll_addr = '0, chk_addr_1 = '0, chk_addr_2 = '0;
  logic [31:0] wb_data = '0, ll_data = '0;
  logic ll_ready, chk_pending_1, chk_pending_2, write_enabled, ll_empty;
  logic [4:0] write_addr;
  logic [31:0] write_data;

  regfile_write_arbiter #(.LL_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_addr(ll_addr), .ll_data(ll_data),
    .chk_addr_1(chk_addr_1), .chk_addr_2(chk_addr_2),
    .chk_pending_1(chk_pending_1), .chk_pending_2(chk_pending_2),
    .write_addr(write_addr), .write_data(write_data), .write_enabled(write_enabled),
    .ll_empty(ll_empty)
  );

  always #5 clk = ~clk;

  typedef struct { bit live; bit [4:0] addr; bit [31:0] data; } ent_t;
  typedef struct { int cyc; bit [4:0] addr; bit [31:0] data; } wr_t;
  ent_t fq[$];
  wr_t wq[$];
  int cyc = 0;
  int n_cmp = 0, n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit pend(input bit [4:0] a);
    foreach (fq[i]) if (fq[i].live && fq[i].addr == a && a != 0) return 1'b1;
    return 1'b0;
  endfunction

  // One cycle: drive inputs, check combinational status against the model, then advance the model.
  task automatic step(input bit r, input bit wv, input bit [4:0] wa, input bit [31:0] wd,
                      input bit lv, input bit [4:0] la, input bit [31:0] ld,
                      input bit [4:0] c1, input bit [4:0] c2);
    bit rdy, go;
    ent_t e;
    @(negedge clk);
    rst = r; wb_valid = wv; wb_addr = wa; wb_data = wd;
    ll_valid = lv; ll_addr = la; ll_data = ld; chk_addr_1 = c1; chk_addr_2 = c2;
    #1;
    rdy = fq.size() < DEPTH;
    if (!r) begin
      chk("ll_ready", ll_ready, rdy);
      chk("ll_empty", ll_empty, fq.size() == 0);
      chk("pending_1", chk_pending_1, pend(c1));
      chk("pending_2", chk_pending_2, pend(c2));
    end
    if (r) begin
      fq.delete();
    end else begin
      go = wv && wa != 0;
      if (go) wq.push_back('{cyc + 1, wa, wd});
      else if (fq.size() > 0) begin
        e = fq.pop_front();
        if (e.live) wq.push_back('{cyc + 1, e.addr, e.data});
      end
      if (go) foreach (fq[i]) if (fq[i].addr == wa) fq[i].live = 1'b0;
      if (lv && rdy) fq.push_back('{la != 0 && !(go && la == wa), la, ld});
    end
  endtask

  task automatic idle(input int n, input bit [4:0] c1 = 0);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, c1, 0);
  endtask

  // Monitor: every register-file write must match the oldest expected write in content and cycle.
  always @(negedge clk) begin
    if (write_enabled) begin
      if (wq.size() == 0 || wq[0].cyc != cyc) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_write cyc=%0d: got addr %0d data %0h, none expected", cyc, write_addr, write_data);
      end else begin
        chk("write_addr", write_addr, wq[0].addr);
        chk("write_data", write_data, wq[0].data);
        void'(wq.pop_front());
      end
    end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
      n_cmp++; n_err++;
      $display("FAIL missing_write cyc=%0d: got no write, expected addr %0d data %0h", cyc, wq[0].addr, wq[0].data);
      void'(wq.pop_front());
    end
  end

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    chk("reset_we", write_enabled, 0);
    chk("reset_addr", write_addr, 0);
    chk("reset_data", write_data, 0);
    // pipeline only
    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    idle(2);
    // long-latency drain with pending lookup
    step(0, 0, 0, 0, 1, 9, 32'h1234, 9, 0);
    idle(3, 9);
    // starvation and backpressure
    for (int i = 0; i < 5; i++) step(0, 1, 5'(10 + i), 32'(100 + i), 1, 5'(20 + i), 32'(200 + i), 5'(20 + i), 21);
    idle(6);
    // squash
    step(0, 0, 0, 0, 1, 7, 32'h77, 7, 0);
    step(0, 1, 7, 32'hAA, 0, 0, 0, 7, 0);
    step(0, 1, 7, 32'hAB, 1, 7, 32'h78, 7, 0);
    idle(3, 7);
    chk("squash_empty", ll_empty, 1);
    // zero register
    step(0, 1, 4, 32'h44, 1, 3, 32'h33, 3, 0);
    step(0, 1, 0, 32'h99, 1, 0, 32'h55, 3, 0);
    idle(3);
    // mid-reset with 3 entries queued
    for (int i = 0; i < 3; i++) step(0, 1, 1, 32'(i), 1, 5'(2 + i), 32'(50 + i), 2, 3);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    chk("midrst_we", write_enabled, 0);
    chk("midrst_ready", ll_ready, 1);
    chk("midrst_empty", ll_empty, 1);
    idle(4);
    // randomized traffic over a small address range to provoke collisions
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 55, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    idle(DEPTH + 3);
    chk("final_empty", ll_empty, 1);
    chk("scoreboard_drained", wq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
